// File: rtl/delayf_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module   : delayf_ctrl_mc
// Purpose  : Multi-channel synchronous tap controller for programmable input
//            delay lines. Each channel holds a TAP_W-bit delay code. The code
//            can be loaded, or stepped up/down on a falling edge of MOVE. It
//            saturates at 0 and at max, and reports the limit on CFLAG.
// Ports    : CLK        - clock, all logic on rising edge
//            RST        - synchronous reset, active-high
//            LOADN      - per-channel active-low load of LOAD_VAL
//            LOAD_VAL   - shared load code
//            MOVE       - per-channel step request (committed on its fall)
//            DIRECTION  - per-channel step direction (0 = up, 1 = down)
//            TAP        - channel i code at [i*TAP_W +: TAP_W]
//            CFLAG      - channel at limit for its current direction
//            BUSY       - channel settling after a step
//            OVF        - sticky: step requested while saturated
// Options  : DELAYF_MC_MOVE_SYNC_EN - 2-flop synchronizer on MOVE/DIRECTION
// Revision : 1.0 - initial release
// ============================================================================
module delayf_ctrl_mc #(
  parameter int CHANNELS   = 4,
  parameter int TAP_W      = 7,
  parameter int DEL_VALUE  = 0,
  parameter int SETTLE_CYC = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [CHANNELS-1:0]       LOADN,
  input  logic [TAP_W-1:0]          LOAD_VAL,
  input  logic [CHANNELS-1:0]       MOVE,
  input  logic [CHANNELS-1:0]       DIRECTION,
  output logic [CHANNELS*TAP_W-1:0] TAP,
  output logic [CHANNELS-1:0]       CFLAG,
  output logic [CHANNELS-1:0]       BUSY,
  output logic [CHANNELS-1:0]       OVF
);

  localparam logic [TAP_W-1:0] TAP_MAX     = '1;
  localparam logic [TAP_W-1:0] TAP_RST     = DEL_VALUE[TAP_W-1:0];
  localparam logic [3:0]       SETTLE_LOAD = (SETTLE_CYC > 0) ? 4'(SETTLE_CYC - 1) : 4'd0;
  localparam logic             CFLAG_RST   = (TAP_RST == TAP_MAX);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  logic [CHANNELS-1:0] move_in;
  logic [CHANNELS-1:0] dir_in;

`ifdef DELAYF_MC_MOVE_SYNC_EN
  // LOADN deliberately does not touch these flops; only RST clears them.
  logic [CHANNELS-1:0] move_s1_q, move_s2_q;
  logic [CHANNELS-1:0] dir_s1_q, dir_s2_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      move_s1_q <= '0;
      move_s2_q <= '0;
      dir_s1_q  <= '0;
      dir_s2_q  <= '0;
    end else begin
      move_s1_q <= MOVE;
      move_s2_q <= move_s1_q;
      dir_s1_q  <= DIRECTION;
      dir_s2_q  <= dir_s1_q;
    end
  end

  assign move_in = move_s2_q;
  assign dir_in  = dir_s2_q;
`else
  assign move_in = MOVE;
  assign dir_in  = DIRECTION;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             drn_q, drn_d;
    logic             cflag_q, cflag_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;
    logic             move_q;
    logic             fall;

    assign fall = move_q & ~move_in[i];

    always_comb begin
      state_d = state_q;
      tap_d   = tap_q;
      cnt_d   = cnt_q;
      drn_d   = drn_q;
      busy_d  = busy_q;
      ovf_d   = ovf_q;

      if (!LOADN[i]) begin
        // Load wins over any fall seen on this edge; that fall is lost.
        tap_d   = LOAD_VAL;
        drn_d   = 1'b0;
        state_d = IDLE;
        cnt_d   = 4'd0;
        busy_d  = 1'b0;
        ovf_d   = 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (fall) begin
              drn_d = dir_in[i];
              if (!dir_in[i]) begin
                if (tap_q != TAP_MAX) tap_d = tap_q + 1'b1;
                else                  ovf_d = 1'b1;
              end else begin
                if (tap_q != '0)      tap_d = tap_q - 1'b1;
                else                  ovf_d = 1'b1;
              end
              if (SETTLE_CYC > 0) begin
                state_d = SETTLE;
                cnt_d   = SETTLE_LOAD;
                busy_d  = 1'b1;
              end
            end
          end
          SETTLE: begin
            // Falls arriving here are ignored entirely.
            if (cnt_q == 4'd0) begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end else begin
              cnt_d = cnt_q - 4'd1;
            end
          end
          default: state_d = IDLE;
        endcase
      end

      // Derived from the next code/direction so a reversal at a limit
      // clears the flag on the same edge as the step.
      cflag_d = ((tap_d == TAP_MAX) && !drn_d) || ((tap_d == '0) && drn_d);
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        state_q <= IDLE;
        tap_q   <= TAP_RST;
        cnt_q   <= 4'd0;
        drn_q   <= 1'b0;
        cflag_q <= CFLAG_RST;
        busy_q  <= 1'b0;
        ovf_q   <= 1'b0;
        move_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        tap_q   <= tap_d;
        cnt_q   <= cnt_d;
        drn_q   <= drn_d;
        cflag_q <= cflag_d;
        busy_q  <= busy_d;
        ovf_q   <= ovf_d;
        move_q  <= move_in[i];
      end
    end

    assign TAP[i*TAP_W +: TAP_W] = tap_q;
    assign CFLAG[i]              = cflag_q;
    assign BUSY[i]               = busy_q;
    assign OVF[i]                = ovf_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_delayf_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_delayf_ctrl_mc
// Purpose  : Directed self-checking bench for delayf_ctrl_mc (4 channels,
//            7-bit codes, reset code 5, settle of 2 cycles). Honours
//            DELAYF_MC_MOVE_SYNC_EN by adding the 2-cycle synchronizer delay.
// Revision : 1.0 - initial release
// ============================================================================
module tb_delayf_ctrl_mc;

`ifdef DELAYF_MC_MOVE_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  LOADN;
  logic [6:0]  LOAD_VAL;
  logic [3:0]  MOVE;
  logic [3:0]  DIRECTION;
  logic [27:0] TAP;
  logic [3:0]  CFLAG;
  logic [3:0]  BUSY;
  logic [3:0]  OVF;

  int checks = 0;
  int errors = 0;

  delayf_ctrl_mc #(
    .CHANNELS   (4),
    .TAP_W      (7),
    .DEL_VALUE  (5),
    .SETTLE_CYC (2)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .LOADN     (LOADN),
    .LOAD_VAL  (LOAD_VAL),
    .MOVE      (MOVE),
    .DIRECTION (DIRECTION),
    .TAP       (TAP),
    .CFLAG     (CFLAG),
    .BUSY      (BUSY),
    .OVF       (OVF)
  );

  always #5 CLK = ~CLK;

  function automatic logic [6:0] tp(input int ch);
    return TAP[ch*7 +: 7];
  endfunction

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One-cycle high pulse on the masked channels; returns just after the edge
  // on which the fall is committed.
  task automatic pulse(input logic [3:0] m);
    MOVE = m;
    tick();
    MOVE = 4'b0;
    tick();
    repeat (SYNC_LAT) tick();
  endtask

  task automatic load(input logic [3:0] m, input logic [6:0] v);
    LOADN    = ~m;
    LOAD_VAL = v;
    tick();
    LOADN    = 4'hF;
  endtask

  task automatic test_reset();
    RST = 1'b1; LOADN = 4'hF; LOAD_VAL = 7'd0; MOVE = 4'b0; DIRECTION = 4'b0;
    repeat (2) tick();
    RST = 1'b0;
    tick();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (tp(c) !== 7'd5) begin errors++; $display("FAIL reset_tap%0d got %0d exp 5", c, tp(c)); end
    end
    checks++; if (CFLAG !== 4'b0) begin errors++; $display("FAIL reset_cflag got %b exp 0000", CFLAG); end
    checks++; if (BUSY  !== 4'b0) begin errors++; $display("FAIL reset_busy got %b exp 0000", BUSY); end
    checks++; if (OVF   !== 4'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0000", OVF); end
  endtask

  task automatic test_up_saturate();
    load(4'b0001, 7'd126);
    checks++; if (tp(0) !== 7'd126) begin errors++; $display("FAIL load_tap0 got %0d exp 126", tp(0)); end
    checks++; if (CFLAG[0] !== 1'b0) begin errors++; $display("FAIL load_cflag0 got %b exp 0", CFLAG[0]); end
    DIRECTION = 4'b0000;
    pulse(4'b0001);
    checks++; if (tp(0) !== 7'd127) begin errors++; $display("FAIL up_tap0 got %0d exp 127", tp(0)); end
    checks++; if (CFLAG[0] !== 1'b1) begin errors++; $display("FAIL up_cflag0 got %b exp 1", CFLAG[0]); end
    checks++; if (BUSY[0] !== 1'b1) begin errors++; $display("FAIL busy0_c1 got %b exp 1", BUSY[0]); end
    tick();
    checks++; if (BUSY[0] !== 1'b1) begin errors++; $display("FAIL busy0_c2 got %b exp 1", BUSY[0]); end
    tick();
    checks++; if (BUSY[0] !== 1'b0) begin errors++; $display("FAIL busy0_c3 got %b exp 0", BUSY[0]); end
    checks++; if (OVF[0] !== 1'b0) begin errors++; $display("FAIL ovf0_pre got %b exp 0", OVF[0]); end
    pulse(4'b0001);
    checks++; if (tp(0) !== 7'd127) begin errors++; $display("FAIL sat_tap0 got %0d exp 127", tp(0)); end
    checks++; if (OVF[0] !== 1'b1) begin errors++; $display("FAIL sat_ovf0 got %b exp 1", OVF[0]); end
    checks++; if (CFLAG[0] !== 1'b1) begin errors++; $display("FAIL sat_cflag0 got %b exp 1", CFLAG[0]); end
    repeat (2) tick();
  endtask

  task automatic test_down_saturate();
    load(4'b0010, 7'd0);
    checks++; if (CFLAG[1] !== 1'b0) begin errors++; $display("FAIL zero_cflag1 got %b exp 0", CFLAG[1]); end
    DIRECTION = 4'b0010;
    pulse(4'b0010);
    checks++; if (tp(1) !== 7'd0) begin errors++; $display("FAIL dn_tap1 got %0d exp 0", tp(1)); end
    checks++; if (CFLAG[1] !== 1'b1) begin errors++; $display("FAIL dn_cflag1 got %b exp 1", CFLAG[1]); end
    checks++; if (OVF[1] !== 1'b1) begin errors++; $display("FAIL dn_ovf1 got %b exp 1", OVF[1]); end
    repeat (2) tick();
    DIRECTION = 4'b0000;
    pulse(4'b0010);
    checks++; if (tp(1) !== 7'd1) begin errors++; $display("FAIL rev_tap1 got %0d exp 1", tp(1)); end
    checks++; if (CFLAG[1] !== 1'b0) begin errors++; $display("FAIL rev_cflag1 got %b exp 0", CFLAG[1]); end
    checks++; if (OVF[1] !== 1'b1) begin errors++; $display("FAIL sticky_ovf1 got %b exp 1", OVF[1]); end
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    load(4'b0100, 7'd10);
    DIRECTION = 4'b0000;
    MOVE = 4'b0100; tick();
    MOVE = 4'b0000; tick();   // first fall commits (plus sync delay)
    MOVE = 4'b0100; tick();
    MOVE = 4'b0000; tick();   // second fall lands inside settle
    repeat (SYNC_LAT + 3) tick();
    checks++; if (tp(2) !== 7'd11) begin errors++; $display("FAIL b2b_tap2 got %0d exp 11", tp(2)); end
    checks++; if (BUSY[2] !== 1'b0) begin errors++; $display("FAIL b2b_busy2 got %b exp 0", BUSY[2]); end
    checks++; if (OVF[2] !== 1'b0) begin errors++; $display("FAIL b2b_ovf2 got %b exp 0", OVF[2]); end
  endtask

  task automatic test_simultaneous();
    logic [6:0] exp_a [4];
    logic [6:0] exp_b [4];
    exp_a = '{7'd21, 7'd19, 7'd21, 7'd19};
    exp_b = '{7'd22, 7'd18, 7'd22, 7'd50};
    load(4'hF, 7'd20);
    DIRECTION = 4'b1010;
    pulse(4'hF);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (tp(c) !== exp_a[c]) begin errors++; $display("FAIL simul_tap%0d got %0d exp %0d", c, tp(c), exp_a[c]); end
    end
    checks++; if (BUSY !== 4'hF) begin errors++; $display("FAIL simul_busy got %b exp 1111", BUSY); end
    repeat (2) tick();
    // Second round: LOADN[3] coincides with the committing edge.
    MOVE = 4'hF; tick();
    MOVE = 4'h0;
    repeat (SYNC_LAT) tick();
    LOADN = 4'b0111; LOAD_VAL = 7'd50;
    tick();
    LOADN = 4'hF;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (tp(c) !== exp_b[c]) begin errors++; $display("FAIL simld_tap%0d got %0d exp %0d", c, tp(c), exp_b[c]); end
    end
    checks++; if (BUSY !== 4'b0111) begin errors++; $display("FAIL simld_busy got %b exp 0111", BUSY); end
    repeat (2) tick();
  endtask

  task automatic test_hold_high();
    DIRECTION = 4'b0000;
    MOVE = 4'b1000;
    repeat (6) tick();
    checks++; if (tp(3) !== 7'd50) begin errors++; $display("FAIL hold_tap3 got %0d exp 50", tp(3)); end
    checks++; if (BUSY[3] !== 1'b0) begin errors++; $display("FAIL hold_busy3 got %b exp 0", BUSY[3]); end
    MOVE = 4'b0000;
    tick();
    repeat (SYNC_LAT) tick();
    checks++; if (tp(3) !== 7'd51) begin errors++; $display("FAIL release_tap3 got %0d exp 51", tp(3)); end
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_up_saturate();
    test_down_saturate();
    test_back_to_back();
    test_simultaneous();
    test_hold_high();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
